// File: rtl/h_interp_seq.sv
// Channel-estimation interpolation sequencer: walks NSC subcarriers x 7 symbols,
// requesting divides or selecting pilots. Define INTERP_TIMEOUT_EN for the divider watchdog.
module h_interp_seq #(
    parameter int unsigned NSC     = 12,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       est_valid,
    input  logic       div_done,
    input  logic       out_ready,
    output logic       div_start,
    output logic [1:0] sel,
    output logic       h_valid,
    output logic [3:0] sc_idx,
    output logic [2:0] sym_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_EST = 3'd1,
        DIV_REQ  = 3'd2,
        DIV_WAIT = 3'd3,
        EMIT     = 3'd4,
        FIN      = 3'd5
    } state_t;

    localparam logic [1:0] SEL_DIV2 = 2'b00;
    localparam logic [1:0] SEL_EST3 = 2'b01;
    localparam logic [1:0] SEL_EST4 = 2'b11;
    localparam logic [1:0] SEL_DIV1 = 2'b10;
    localparam logic [3:0] SC_LAST  = 4'(NSC - 1);
    localparam logic [2:0] SYM_LAST = 3'd6;

    // Elaboration-time guard on the configuration range.
    if (NSC < 1 || NSC > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("h_interp_seq: NSC must be 1..16 and TIMEOUT at least 1");
    end

    state_t     state;
    logic [2:0] sym_next;

    assign sym_next = sym_idx + 3'd1;

    // Symbols 0, 2 and 4 are the interpolated ones that need a fresh divide.
    function automatic logic needs_div(input logic [2:0] sym);
        needs_div = (sym == 3'd0) || (sym == 3'd2) || (sym == 3'd4);
    endfunction

    function automatic logic [1:0] sel_for(input logic [2:0] sym);
        case (sym)
            3'd1, 3'd3: sel_for = SEL_DIV2;
            3'd5:       sel_for = SEL_EST3;
            3'd6:       sel_for = SEL_EST4;
            default:    sel_for = SEL_DIV1;
        endcase
    endfunction

`ifdef INTERP_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            div_start <= 1'b0;
            sel       <= SEL_DIV2;
            h_valid   <= 1'b0;
            sc_idx    <= '0;
            sym_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef INTERP_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            div_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sc_idx  <= '0;
                        sym_idx <= '0;
                        busy    <= 1'b1;
                        state   <= WAIT_EST;
`ifdef INTERP_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                WAIT_EST: begin
                    if (est_valid) begin
                        if (needs_div(sym_idx)) begin
                            div_start <= 1'b1;
                            state     <= DIV_REQ;
                        end else begin
                            sel     <= sel_for(sym_idx);
                            h_valid <= 1'b1;
                            state   <= EMIT;
                        end
                    end
                end
                // div_done in the request cycle is deliberately not looked at.
                DIV_REQ: begin
                    state <= DIV_WAIT;
`ifdef INTERP_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        sel     <= SEL_DIV1;
                        h_valid <= 1'b1;
                        state   <= EMIT;
                    end
`ifdef INTERP_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end
                EMIT: begin
                    if (out_ready) begin
                        if (sym_idx != SYM_LAST) begin
                            sym_idx <= sym_next;
                            if (needs_div(sym_next)) begin
                                h_valid   <= 1'b0;
                                div_start <= 1'b1;
                                state     <= DIV_REQ;
                            end else begin
                                sel <= sel_for(sym_next);
                            end
                        end else if (sc_idx != SC_LAST) begin
                            sym_idx <= '0;
                            sc_idx  <= sc_idx + 4'd1;
                            h_valid <= 1'b0;
                            state   <= WAIT_EST;
                        end else begin
                            h_valid <= 1'b0;
                            done    <= 1'b1;
                            state   <= FIN;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/h_interp_seq.md
# h_interp_seq

Sequencer for the channel-estimation interpolation stage. It walks every subcarrier of a slot through its seven OFDM symbols. For each symbol it either requests a division from the interpolation divider or selects a pilot estimate. It then drives the 2-bit select of the equalizer-channel output mux, handing each selected channel value to the equalizer with a valid/ready handshake. It sits between the pilot estimator (est3/est4 producer), the divider, and the equalizer.

## Interface
- NSC, 12: subcarriers per slot; legal range 1..16.
- TIMEOUT, 15: divider watchdog limit in cycles; used only with the Configuration macro.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one slot; sampled only in IDLE.
- est_valid  in  1  est3/est4 for the current subcarrier are stable.
- div_done  in  1  one-cycle pulse; div_res_1/div_res_2 are valid.
- out_ready  in  1  equalizer accepts the current channel value.
- div_start  out  1  one-cycle divider request.
- sel  out  2  mux select: 00 = div_res_2, 01 = est3, 11 = est4, 10 = div_res_1.
- h_valid  out  1  selected channel value is valid.
- sc_idx  out  4  current subcarrier index.
- sym_idx  out  3  current symbol index, 0..6.
- busy  out  1  high from the start accept until done.
- done  out  1  one-cycle pulse after the last symbol of the last subcarrier.
- err  out  1  divider timeout flag; sticky until the next start. Only with INTERP_TIMEOUT_EN; otherwise tied 0.

## Operation
- States: IDLE, WAIT_EST, DIV_REQ, DIV_WAIT, EMIT, FIN.
- IDLE: on start=1, clear sc_idx, sym_idx and err, then go to WAIT_EST. start is ignored in every other state.
- WAIT_EST: wait for est_valid=1, then dispatch on sym_idx.
- Symbol schedule, per subcarrier:
  - sym 0, 2, 4: go to DIV_REQ, assert div_start for one cycle, then DIV_WAIT until div_done. Then EMIT with sel=10.
  - sym 1, 3: go straight to EMIT with sel=00, reusing div_res_2 of the previous request.
  - sym 5: EMIT with sel=01.
  - sym 6: EMIT with sel=11.
- EMIT: h_valid=1; sel, sc_idx and sym_idx are held stable until out_ready=1.
- On the handshake cycle:
  - sym_idx < 6: increment sym_idx. Continue with DIV_REQ for even indices ≤ 4, otherwise stay in EMIT.
  - sym_idx = 6 and sc_idx < NSC-1: sym_idx to 0, increment sc_idx, go to WAIT_EST.
  - sym_idx = 6 and sc_idx = NSC-1: go to FIN.
- FIN: pulse done for one cycle, drop busy, return to IDLE.
- A div_done pulse outside DIV_WAIT is ignored.
- A div_done pulse in the same cycle as div_start is ignored; divider latency is at least 1.
- Reset mid-slot: immediate return to IDLE; no partial done.
- Reset values: IDLE; div_start, h_valid, busy, done and err = 0; sel=00; sc_idx=0; sym_idx=0.

## Timing
- start at cycle t → busy=1 at t+1.
- est_valid high at WAIT_EST entry → div_start at the next cycle.
- div_done at cycle d → h_valid=1 with sel=10 at d+1.
- Handshake at cycle h (h_valid=1 and out_ready=1):
  - next symbol needs no divide: next h_valid at h+1, so back-to-back odd and pilot symbols give one value per cycle.
  - next symbol needs a divide: div_start at h+1.
- Minimum per subcarrier with zero-latency handshakes and divider latency L: 3·(L+2) + 4 cycles, plus 1 cycle in WAIT_EST.
- done asserts the cycle after the final handshake.
- All outputs are registered.

## Configuration
- INTERP_TIMEOUT_EN defined: a counter runs in DIV_WAIT.
  - If TIMEOUT cycles pass without div_done: set err=1, drop busy, return to IDLE with no done pulse.
  - The counter resets on every entry to DIV_WAIT.
- INTERP_TIMEOUT_EN undefined: DIV_WAIT waits indefinitely; err is constant 0 and no counter is built.

## Test plan
- Nominal slot, NSC=2, divider latency 3, out_ready=1: exactly 6 div_start pulses and 14 h_valid beats. sel sequence per subcarrier is 10,00,10,00,10,01,11. done fires once, one cycle after the 14th beat.
- Backpressure: out_ready=0 for 5 cycles during sym 3 → sel=00, sc_idx and sym_idx held; no div_start until 1 cycle after the handshake.
- est_valid low for 4 cycles at subcarrier 1 entry → no div_start and no h_valid until est_valid rises.
- Spurious div_done during EMIT and start pulses while busy → no state change, no extra beat.
- Reset asserted in DIV_WAIT → all outputs at reset values in the same cycle. A new start then runs a clean slot from sc 0, sym 0.
- With INTERP_TIMEOUT_EN and TIMEOUT=15, divider never responds → err=1 and busy=0 exactly 15 cycles into DIV_WAIT; done stays 0. Without the macro, the block holds in DIV_WAIT.
